// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control/status bundle of the UART baud-rate generator.
// The master side (UART core or bench) drives divisor, load, sync and clock
// enable. The slave side (uart_baud_gen) returns the oversample strobes and
// the oversample count.
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int CNT_W  = 4
);
  logic              i_ce;
  logic [DIV_W-1:0]  i_div;
  logic [FRAC_W-1:0] i_frac;
  logic              i_load;
  logic              i_sync;
  logic              o_os_tick;
  logic              o_mid_tick;
  logic              o_bit_tick;
  logic [CNT_W-1:0]  o_os_cnt;

  modport master (
    output i_ce, i_div, i_frac, i_load, i_sync,
    input  o_os_tick, o_mid_tick, o_bit_tick, o_os_cnt
  );

  modport slave (
    input  i_ce, i_div, i_frac, i_load, i_sync,
    output o_os_tick, o_mid_tick, o_bit_tick, o_os_cnt
  );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable UART baud-rate generator.
// A prescaler divides i_clk (qualified by i_ce) by a loadable divisor to make
// an oversample tick; an oversample counter on top of it yields mid-bit and
// bit strobes. A new divisor is written to shadow registers by i_load and
// adopted at the next period boundary; i_sync restarts the bit phase.
// Optional feature macro: UART_BAUD_FRAC_EN adds a fractional accumulator so
// the period alternates between div and div+1 clocks. Without it i_frac is
// ignored and every period is exactly max(div,1) clocks.
module uart_baud_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_baud_gen_if.slave bus
);

  localparam int               CNT_W    = $clog2(OSR);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_a_q, div_a_d;
  logic [DIV_W-1:0] div_s_q, div_s_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;

  logic             ext;       // current period is one clock longer
  logic [DIV_W-1:0] pre_last;  // prescaler value of the terminal cycle (L-1)
  logic             terminal;
  logic [DIV_W-1:0] div_new;   // divisor adopted when the period restarts

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W-1:0] frac_a_q, frac_a_d;
  logic [FRAC_W-1:0] frac_s_q, frac_s_d;
  logic [FRAC_W-1:0] frac_new;

  assign ext      = ext_q;
  assign frac_new = (bus.i_sync && bus.i_load) ? bus.i_frac : frac_s_q;
`else
  logic unused_frac;

  assign ext         = 1'b0;
  assign unused_frac = ^bus.i_frac;
`endif

  // A divisor of 0 behaves as 1; the carry stretches the period by one clock.
  assign pre_last = ((div_a_q == '0) ? '0 : div_a_q - DIV_ONE) + DIV_W'(ext);
  assign terminal = bus.i_ce && (pre_q == pre_last);
  // A sync that coincides with a load bypasses the shadow register.
  assign div_new  = (bus.i_sync && bus.i_load) ? bus.i_div : div_s_q;

  // Next-state logic: sync beats the terminal-cycle update, which beats hold.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pre_d      = pre_q;
    div_a_d    = div_a_q;
    div_s_d    = bus.i_load ? bus.i_div : div_s_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    acc_d      = acc_q;
    ext_d      = ext_q;
    frac_a_d   = frac_a_q;
    frac_s_d   = bus.i_load ? bus.i_frac : frac_s_q;
`endif
    if (bus.i_sync) begin
      // The sync cycle itself counts as clock 0 of the new period, so the
      // first tick lands L cycles after it. With L=1 it is not counted, which
      // keeps the cycle right after sync free of ticks.
      pre_d    = (bus.i_ce && (div_new > DIV_ONE)) ? DIV_ONE : '0;
      div_a_d  = div_new;
      os_cnt_d = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_d    = '0;
      ext_d    = 1'b0;
      frac_a_d = frac_new;
`endif
    end else if (terminal) begin
      pre_d      = '0;
      div_a_d    = div_s_q;
      os_cnt_d   = os_cnt_q + CNT_ONE;
      os_tick_d  = 1'b1;
      mid_tick_d = (os_cnt_d == MID_CNT);
      bit_tick_d = (os_cnt_q == LAST_CNT);
`ifdef UART_BAUD_FRAC_EN
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_a_q};
      frac_a_d       = frac_s_q;
`endif
    end else if (bus.i_ce) begin
      pre_d = pre_q + DIV_ONE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (i_rst) begin
      pre_q      <= '0;
      div_a_q    <= DEF_DIV;
      div_s_q    <= DEF_DIV;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      acc_q      <= '0;
      ext_q      <= 1'b0;
      frac_a_q   <= '0;
      frac_s_q   <= '0;
`endif
    end else begin
      pre_q      <= pre_d;
      div_a_q    <= div_a_d;
      div_s_q    <= div_s_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
`ifdef UART_BAUD_FRAC_EN
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      frac_a_q   <= frac_a_d;
      frac_s_q   <= frac_s_d;
`endif
    end
  end

  assign bus.o_os_tick  = os_tick_q;
  assign bus.o_mid_tick = mid_tick_q;
  assign bus.o_bit_tick = bit_tick_q;
  assign bus.o_os_cnt   = os_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: scoreboard bench for uart_baud_gen (DIV_W=16, FRAC_W=4,
// OSR=16, DEFAULT_DIV=27). Stimulus pushes every expected os tick (cycle,
// count, mid/bit flags) into a queue; a negedge monitor pops one entry per
// observed tick. Cycle k is the clock period that follows rising edge k.
module tb_uart_baud_gen;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic       mid;
    logic       bt;
  } tick_t;

  logic  clk = 1'b0;
  logic  rst;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  tick_t exp_q[$];

  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4), .CNT_W(4)) bif ();

  uart_baud_gen #(
    .DIV_W(16), .FRAC_W(4), .OSR(16), .DEFAULT_DIV(27)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected tick: k is the number of ticks since the counter was cleared.
  task automatic push_tick(input int c, input int k);
    tick_t t;
    t.cyc = c;
    t.cnt = 4'(k % 16);
    t.mid = ((k % 16) == 8);
    t.bt  = ((k % 16) == 0);
    exp_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int e);
    while (cyc < e) step();
  endtask

  // Monitor: every observed tick must match the head of the queue; strobes
  // without an os tick are always wrong.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (bif.o_os_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_tick @cycle %0d: got tick expected none", cyc);
        end else begin
          tick_t t;
          t = exp_q.pop_front();
          check("tick_cycle", cyc, t.cyc);
          check("tick_flags_mid_bit_cnt",
                {26'd0, bif.o_mid_tick, bif.o_bit_tick, bif.o_os_cnt},
                {26'd0, t.mid, t.bt, t.cnt});
        end
      end else begin
        check("strobe_without_tick", {30'd0, bif.o_mid_tick, bif.o_bit_tick}, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s, s2, s3, s4, s5, r1, s6;
    int frac_off[7];
    frac_off = '{4, 8, 13, 17, 22, 26, 31};

    rst        = 1'b1;
    bif.i_ce   = 1'b0;
    bif.i_div  = '0;
    bif.i_frac = '0;
    bif.i_load = 1'b0;
    bif.i_sync = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_os_tick",  bif.o_os_tick, 0);
    check("rst_mid_tick", bif.o_mid_tick, 0);
    check("rst_bit_tick", bif.o_bit_tick, 0);
    check("rst_os_cnt",   bif.o_os_cnt, 0);

    // Default rate: ticks at 27, 54, ..., bit tick at 432 with count 0.
    r0 = cyc;
    rst = 1'b0;
    bif.i_ce = 1'b1;
    for (int k = 1; k <= 16; k++) push_tick(r0 + 27 * k, k);
    run_until(r0 + 442);
    check("drain_default", exp_q.size(), 0);

    // Load div=4 with the prescaler at 10: period still ends at 27.
    bif.i_load = 1'b1;
    bif.i_div  = 16'd4;
    step();
    bif.i_load = 1'b0;
    for (int k = 17; k <= 43; k++) push_tick(r0 + 459 + 4 * (k - 17), k);

    // Sync at an arbitrary phase with count 11.
    s = r0 + 565;
    run_until(s);
    check("drain_load", exp_q.size(), 0);
    check("pre_sync_os_cnt", bif.o_os_cnt, 11);
    bif.i_sync = 1'b1;
    step();
    bif.i_sync = 1'b0;
    check("post_sync_os_cnt",  bif.o_os_cnt, 0);
    check("post_sync_os_tick", bif.o_os_tick, 0);
    for (int m = 1; m <= 17; m++) push_tick(s + 4 * m, m);
    run_until(s + 70);
    check("drain_sync", exp_q.size(), 0);

    // Fractional divisor 4 + 8/16.
    s2 = cyc;
    bif.i_sync = 1'b1;
    bif.i_load = 1'b1;
    bif.i_div  = 16'd4;
    bif.i_frac = 4'd8;
    step();
    bif.i_sync = 1'b0;
    bif.i_load = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    for (int m = 0; m < 7; m++) push_tick(s2 + frac_off[m], m + 1);
`else
    for (int m = 1; m <= 8; m++) push_tick(s2 + 4 * m, m);
`endif
    run_until(s2 + 33);
    check("drain_frac", exp_q.size(), 0);

    // Clock enable toggling with div=2: one tick per 4 clocks.
    s3 = cyc;
    bif.i_sync = 1'b1;
    bif.i_load = 1'b1;
    bif.i_div  = 16'd2;
    bif.i_frac = 4'd0;
    step();
    bif.i_sync = 1'b0;
    bif.i_load = 1'b0;
    for (int m = 0; m < 8; m++) push_tick(s3 + 3 + 4 * m, m + 1);
    while (cyc < s3 + 33) begin
      bif.i_ce = ((cyc - s3) % 2 == 0);
      step();
    end
    bif.i_ce = 1'b1;
    check("drain_ce", exp_q.size(), 0);

    // div=0 acts as 1: a tick every cycle (none right after the sync).
    s4 = cyc;
    bif.i_sync = 1'b1;
    bif.i_load = 1'b1;
    bif.i_div  = 16'd0;
    step();
    bif.i_sync = 1'b0;
    bif.i_load = 1'b0;
    check("div0_no_tick_after_sync", bif.o_os_tick, 0);
    for (int j = 1; j <= 20; j++) push_tick(s4 + 1 + j, j);
    run_until(s4 + 21);
    bif.i_ce = 1'b0;
    step();
    check("drain_div0", exp_q.size(), 0);

    // Reset and sync together at count 7: outputs clear, divisor back to 27.
    s5 = cyc;
    bif.i_ce   = 1'b1;
    bif.i_sync = 1'b1;
    bif.i_load = 1'b1;
    bif.i_div  = 16'd5;
    step();
    bif.i_sync = 1'b0;
    bif.i_load = 1'b0;
    for (int m = 1; m <= 7; m++) push_tick(s5 + 5 * m, m);
    run_until(s5 + 37);
    check("drain_div5", exp_q.size(), 0);
    check("pre_rst_os_cnt", bif.o_os_cnt, 7);
    rst = 1'b1;
    bif.i_sync = 1'b1;
    step();
    rst = 1'b0;
    bif.i_sync = 1'b0;
    check("rst_sync_os_tick",  bif.o_os_tick, 0);
    check("rst_sync_mid_tick", bif.o_mid_tick, 0);
    check("rst_sync_bit_tick", bif.o_bit_tick, 0);
    check("rst_sync_os_cnt",   bif.o_os_cnt, 0);
    r1 = cyc;
    push_tick(r1 + 27, 1);
    push_tick(r1 + 54, 2);
    run_until(r1 + 60);
    check("drain_rst_default", exp_q.size(), 0);

    // Sync with load of div=6 in the same cycle: next tick 6 cycles later.
    s6 = cyc;
    bif.i_sync = 1'b1;
    bif.i_load = 1'b1;
    bif.i_div  = 16'd6;
    step();
    bif.i_sync = 1'b0;
    bif.i_load = 1'b0;
    for (int m = 1; m <= 3; m++) push_tick(s6 + 6 * m, m);
    run_until(s6 + 20);
    check("drain_sync_load", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Runtime-programmable UART baud-rate generator that replaces the fixed-modulus bit counter. It divides the system clock by a loadable integer divisor, with an optional fractional extension, to produce an oversample tick. An oversample counter on top of that tick yields per-bit and mid-bit strobes. TX and RX shifters share one instance per UART, and RX uses `i_sync` to align the bit phase to the start-bit edge.

## Interface
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor; one fractional LSB equals 1/2^FRAC_W clock.
- `OSR`, 16: oversample ratio; a power of two, at least 4.
- `DEFAULT_DIV`, 27: integer divisor after reset; must be at least 1.
- `CNT_W`, `$clog2(OSR)`: width of the oversample counter; derived, not overridden.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. Synchronous, active-high.
- `i_ce`, in, 1: clock enable. When low, all state freezes.
- `i_div`, in, DIV_W: integer divisor; a value of 0 is treated as 1.
- `i_frac`, in, FRAC_W: fractional divisor.
- `i_load`, in, 1: one-cycle strobe that latches `i_div`/`i_frac` into the shadow registers.
- `i_sync`, in, 1: restarts the prescaler, the accumulator and the oversample counter.
- `o_os_tick`, out, 1: oversample tick; a one-cycle pulse.
- `o_mid_tick`, out, 1: pulse on the os tick at which `o_os_cnt` becomes OSR/2.
- `o_bit_tick`, out, 1: pulse on the os tick at which `o_os_cnt` wraps from OSR-1 to 0.
- `o_os_cnt`, out, CNT_W: current oversample count.

## Operation
- Registers:
  - Prescaler `pre` (DIV_W bits).
  - Active divisor `div_a`/`frac_a`; shadow divisor `div_s`/`frac_s`.
  - Accumulator `acc` (FRAC_W bits) and carry flag `ext`.
  - Oversample counter `os_cnt`.
- **Period:** length L = max(div_a,1) + ext clocks of `i_ce`. `pre` counts 0..L-1.
- **Terminal cycle** (`i_ce`=1, `pre`=L-1):
  - `pre` <= 0.
  - {ext, acc} <= acc + frac_a.
  - div_a/frac_a <= shadow values.
  - os_cnt <= os_cnt+1, modulo OSR.
- **`i_load`:** the shadow registers take `i_div`/`i_frac`. The new value takes effect from the next period boundary; the current period finishes with the old divisor.
- **`i_sync`:**
  - `pre`, `acc`, `ext` and `os_cnt` are cleared.
  - div_a/frac_a <= shadow values. If `i_load` is high in the same cycle, `i_div`/`i_frac` are used directly.
  - No tick is generated in the following cycle.
  - `i_sync` acts regardless of `i_ce`.
- **Priority:** `i_rst` > `i_sync` > terminal-cycle update > hold.
- **`i_ce`=0:** `pre`, `acc`, `ext` and `os_cnt` hold.
- **Reset values:**
  - `pre`, `acc`, `ext`, `os_cnt` = 0.
  - div_a = div_s = DEFAULT_DIV; frac_a = frac_s = 0.
  - All tick outputs = 0.

## Timing
- All outputs are registered.
- `o_os_tick` is set in the cycle after a terminal cycle and is low in every other cycle. It is never high for two consecutive cycles unless L=1 and `i_ce` is held high.
- `o_mid_tick` and `o_bit_tick` are only ever high together with `o_os_tick`. `o_os_cnt` shows the post-increment value in the same cycle.
- From the first cycle with `i_rst`=0 and `i_ce` held high, the first `o_os_tick` is high in cycle DEFAULT_DIV (counting that first cycle as cycle 0). After that, ticks occur every L cycles.
- After `i_sync` in cycle s, the first `o_os_tick` occurs in cycle s+L and the first `o_mid_tick` in cycle s+(OSR/2)·L, assuming `i_ce` is high and frac is 0.
- A reset in mid-period aborts the period. No partial tick is emitted.

## Configuration
- `UART_BAUD_FRAC_EN` defined: the fractional accumulator and `ext` are present, and the period alternates between div and div+1 as described above.
- `UART_BAUD_FRAC_EN` undefined: `acc`, `ext` and `frac_a`/`frac_s` are removed and `ext` is constant 0. `i_frac` remains a port but is ignored, so L = max(div_a,1) exactly.

## Test plan
- **Reset and default rate:** reset, then hold `i_ce`=1 with DEFAULT_DIV=27 → `o_os_tick` in cycles 27, 54, 81…; `o_bit_tick` first in cycle 432 with `o_os_cnt`=0.
- **Load in mid-period:** `i_load` with `i_div`=4 at `pre`=10 while divisor=27 → the current period still ends at 27 cycles, then ticks follow every 4 cycles.
- **Fractional divisor** (`UART_BAUD_FRAC_EN`, div=4, frac=8): period lengths after sync are 4,4,5,4,5,4,5… With the macro undefined, every period is 4.
- **Sync realignment:** div=4, `i_sync` at arbitrary phase with `o_os_cnt`=11 → `o_os_cnt`=0 next cycle, first os tick 4 cycles after sync, `o_mid_tick` 32 cycles after sync, `o_bit_tick` 64 cycles after sync.
- **Clock-enable gating:** div=2, `i_ce` toggling 1,0,1,0 → one tick per 4 clocks; all counters hold while `i_ce`=0. div=0 with `i_ce`=1 → `o_os_tick` high every cycle.
- **Priority and mid-operation reset:**
  - `i_rst` and `i_sync` asserted together at `o_os_cnt`=7 → all outputs 0 next cycle and divisor back to DEFAULT_DIV.
  - `i_sync` and `i_load` together (`i_div`=6) → next tick 6 cycles later.
